// File: rtl/apb_slave_bridge.sv
// APB slave to register-file bridge: one outstanding transfer, registered outputs.
// Ports: APB slave (psel/penable/pwrite/paddr/pwdata/pstrb -> pready/pslverr/prdata),
//        busy_i write gate, RF request side (rf_req/we/addr/wdata/be <- rf_ack/rdata/err).
module apb_slave_bridge #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = BUS_WIDTH / 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [BUS_WIDTH-1:0]  pwdata_i,
    input  logic [STRB_WIDTH-1:0] pstrb_i,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [BUS_WIDTH-1:0]  prdata_o,
    input  logic                  busy_i,
    output logic                  rf_req_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [BUS_WIDTH-1:0]  rf_wdata_o,
    output logic [STRB_WIDTH-1:0] rf_be_o,
    input  logic                  rf_ack_i,
    input  logic [BUS_WIDTH-1:0]  rf_rdata_i,
    input  logic                  rf_err_i
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_abort;
    logic                  w_abort_nxt;
    logic                  w_abort_now;
    logic                  w_misalign;
    logic                  w_setup;

    logic                  r_pready;
    logic                  r_pslverr;
    logic [BUS_WIDTH-1:0]  r_prdata;
    logic                  r_rf_req;
    logic                  r_rf_we;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [BUS_WIDTH-1:0]  r_rf_wdata;
    logic [STRB_WIDTH-1:0] r_rf_be;

    logic                  w_pready_nxt;
    logic                  w_pslverr_nxt;
    logic [BUS_WIDTH-1:0]  w_prdata_nxt;
    logic                  w_rf_req_nxt;
    logic                  w_rf_we_nxt;
    logic [ADDR_WIDTH-1:0] w_rf_addr_nxt;
    logic [BUS_WIDTH-1:0]  w_rf_wdata_nxt;
    logic [STRB_WIDTH-1:0] w_rf_be_nxt;

    assign w_misalign  = |(paddr_i & ALIGN_MASK);
    assign w_setup     = psel_i && !penable_i;
    // Once the master drops psel mid-transfer the response is thrown away.
    assign w_abort_now = r_abort || !psel_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_rf_req   <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rf_be    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_abort    <= w_abort_nxt;
            r_pready   <= w_pready_nxt;
            r_pslverr  <= w_pslverr_nxt;
            r_prdata   <= w_prdata_nxt;
            r_rf_req   <= w_rf_req_nxt;
            r_rf_we    <= w_rf_we_nxt;
            r_rf_addr  <= w_rf_addr_nxt;
            r_rf_wdata <= w_rf_wdata_nxt;
            r_rf_be    <= w_rf_be_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_abort_nxt    = r_abort;
        w_pready_nxt   = 1'b0;
        w_pslverr_nxt  = 1'b0;
        w_prdata_nxt   = '0;
        w_rf_req_nxt   = 1'b0;
        w_rf_we_nxt    = r_rf_we;
        w_rf_addr_nxt  = r_rf_addr;
        w_rf_wdata_nxt = r_rf_wdata;
        w_rf_be_nxt    = r_rf_be;

        unique case (r_state)
            IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_setup) begin
                    if (w_misalign || (pwrite_i && busy_i)) begin
                        w_state_nxt   = RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                    end else if (pwrite_i && (pstrb_i == '0)) begin
                        w_state_nxt  = RESP;
                        w_pready_nxt = 1'b1;
                    end else begin
                        // Capture straight into the RF outputs; REQ is next.
                        w_state_nxt    = REQ;
                        w_cnt_nxt      = '0;
                        w_rf_req_nxt   = 1'b1;
                        w_rf_we_nxt    = pwrite_i;
                        w_rf_addr_nxt  = paddr_i;
                        w_rf_wdata_nxt = pwrite_i ? pwdata_i : '0;
                        w_rf_be_nxt    = pwrite_i ? pstrb_i : '1;
                    end
                end
            end
            REQ: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
                if (!psel_i) begin
                    w_abort_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (!psel_i) begin
                    w_abort_nxt = 1'b1;
                end
                if (rf_ack_i) begin
                    if (w_abort_now) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = rf_err_i;
                        w_prdata_nxt  = r_rf_we ? '0 : rf_rdata_i;
                    end
                end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
                    if (w_abort_now) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign pready_o   = r_pready;
    assign pslverr_o  = r_pslverr;
    assign prdata_o   = r_prdata;
    assign rf_req_o   = r_rf_req;
    assign rf_we_o    = r_rf_we;
    assign rf_addr_o  = r_rf_addr;
    assign rf_wdata_o = r_rf_wdata;
    assign rf_be_o    = r_rf_be;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// Directed bench for apb_slave_bridge: APB master plus a simple RF responder.
// Ports: drives every DUT input, checks outputs one cycle at a time.
module tb_apb_slave_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [15:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic        pready_o;
    logic        pslverr_o;
    logic [31:0] prdata_o;
    logic        busy_i;
    logic        rf_req_o;
    logic        rf_we_o;
    logic [15:0] rf_addr_o;
    logic [31:0] rf_wdata_o;
    logic [3:0]  rf_be_o;
    logic        rf_ack_i;
    logic [31:0] rf_rdata_i;
    logic        rf_err_i;

    int n_chk  = 0;
    int n_pass = 0;

    int          o_cyc;
    int          o_reqs;
    logic        o_err;
    logic [31:0] o_rdata;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic [15:0] o_addr;
    logic        o_we;
    logic        o_after;

    apb_slave_bridge #(
        .BUS_WIDTH (32),
        .ADDR_WIDTH(16),
        .TIMEOUT   (15)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .pstrb_i   (pstrb_i),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .prdata_o  (prdata_o),
        .busy_i    (busy_i),
        .rf_req_o  (rf_req_o),
        .rf_we_o   (rf_we_o),
        .rf_addr_o (rf_addr_o),
        .rf_wdata_o(rf_wdata_o),
        .rf_be_o   (rf_be_o),
        .rf_ack_i  (rf_ack_i),
        .rf_rdata_i(rf_rdata_i),
        .rf_err_i  (rf_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // delay = WAIT cycles before ack (ack in WAIT cycle delay+1); -1 = never.
    task automatic xfer(input logic wr, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int delay, input logic [31:0] rdata,
                        input logic err);
        int  w;
        logic pend;
        o_cyc = 0; o_reqs = 0; o_err = 0; o_rdata = '0;
        o_be = '0; o_wdata = '0; o_addr = '0; o_we = 0; o_after = 1;
        pend = 0; w = 0;
        psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr;
        pwdata_i = wdata; pstrb_i = strb;
        rf_rdata_i = rdata; rf_err_i = err;
        for (int c = 1; c <= 40; c++) begin
            step();
            penable_i = 1;
            rf_ack_i = 0;
            if (pready_o) begin
                o_cyc = c; o_err = pslverr_o; o_rdata = prdata_o;
                break;
            end
            if (rf_req_o) begin
                o_reqs++;
                o_be = rf_be_o; o_wdata = rf_wdata_o;
                o_addr = rf_addr_o; o_we = rf_we_o;
                pend = 1; w = 0;
            end else if (pend) begin
                if (w == delay) begin
                    rf_ack_i = 1;
                    pend = 0;
                end
                w++;
            end
        end
        psel_i = 0; penable_i = 0; rf_ack_i = 0;
        step();
        o_after = pready_o | pslverr_o | (|prdata_o) | rf_req_o;
        if (rf_req_o) o_reqs++;
    endtask

    initial begin
        int pr;
        rst_ni = 0; psel_i = 0; penable_i = 0; pwrite_i = 0;
        paddr_i = '0; pwdata_i = '0; pstrb_i = '0; busy_i = 0;
        rf_ack_i = 0; rf_rdata_i = '0; rf_err_i = 0;
        #22;
        check("rst_outs", {31'd0, pready_o | pslverr_o | rf_req_o | rf_we_o
              | (|prdata_o) | (|rf_addr_o) | (|rf_wdata_o) | (|rf_be_o)}, 32'd0);
        rst_ni = 1;
        step();

        xfer(1, 16'h0004, 32'hDEADBEEF, 4'b0101, 0, 32'h0, 0);
        check("wr_cyc", o_cyc, 3);
        check("wr_reqs", o_reqs, 1);
        check("wr_be", {28'd0, o_be}, 32'h5);
        check("wr_wdata", o_wdata, 32'hDEADBEEF);
        check("wr_addr", {16'd0, o_addr}, 32'h4);
        check("wr_we", {31'd0, o_we}, 1);
        check("wr_err", {31'd0, o_err}, 0);
        check("wr_prdata", o_rdata, 0);
        check("wr_after", {31'd0, o_after}, 0);

        busy_i = 1;
        xfer(0, 16'h0008, 32'h0, 4'b0000, 4, 32'h12345678, 0);
        busy_i = 0;
        check("rd_cyc", o_cyc, 7);
        check("rd_reqs", o_reqs, 1);
        check("rd_be", {28'd0, o_be}, 32'hF);
        check("rd_we", {31'd0, o_we}, 0);
        check("rd_data", o_rdata, 32'h12345678);
        check("rd_err", {31'd0, o_err}, 0);
        check("rd_after", {31'd0, o_after}, 0);

        xfer(0, 16'h0010, 32'h0, 4'b0000, -1, 32'hFFFFFFFF, 0);
        check("to_cyc", o_cyc, 17);
        check("to_reqs", o_reqs, 1);
        check("to_err", {31'd0, o_err}, 1);
        check("to_prdata", o_rdata, 0);
        check("to_after", {31'd0, o_after}, 0);

        xfer(0, 16'h0020, 32'h0, 4'b0000, 1, 32'h000000AA, 1);
        check("rferr_cyc", o_cyc, 4);
        check("rferr_err", {31'd0, o_err}, 1);
        check("rferr_data", o_rdata, 32'hAA);

        busy_i = 1;
        xfer(1, 16'h0004, 32'h11111111, 4'b1111, 0, 32'h0, 0);
        busy_i = 0;
        check("busy_cyc", o_cyc, 1);
        check("busy_reqs", o_reqs, 0);
        check("busy_err", {31'd0, o_err}, 1);

        xfer(0, 16'h0003, 32'h0, 4'b0000, 0, 32'h0, 0);
        check("mis_cyc", o_cyc, 1);
        check("mis_reqs", o_reqs, 0);
        check("mis_err", {31'd0, o_err}, 1);

        xfer(1, 16'h000C, 32'h22222222, 4'b0000, 0, 32'h0, 0);
        check("nostrb_cyc", o_cyc, 1);
        check("nostrb_reqs", o_reqs, 0);
        check("nostrb_err", {31'd0, o_err}, 0);

        // Master abort: drop psel in WAIT, ack later, no response.
        psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 16'h0014;
        step();
        penable_i = 1;
        step();
        psel_i = 0; penable_i = 0;
        pr = 0;
        for (int c = 0; c < 6; c++) begin
            rf_ack_i = (c == 2);
            step();
            if (pready_o) pr++;
        end
        rf_ack_i = 0;
        check("abort_pready", pr, 0);

        xfer(1, 16'h0018, 32'hCAFEF00D, 4'b1000, 2, 32'h0, 0);
        check("postabort_cyc", o_cyc, 5);
        check("postabort_be", {28'd0, o_be}, 32'h8);

        // Reset during WAIT.
        psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = 16'h0020;
        pwdata_i = 32'h55AA55AA; pstrb_i = 4'hF;
        step();
        penable_i = 1;
        step();
        step();
        check("prerst_we", {31'd0, rf_we_o}, 1);
        #2 rst_ni = 0;
        #1;
        check("rst_async", {31'd0, pready_o | pslverr_o | rf_req_o | rf_we_o
              | (|prdata_o) | (|rf_addr_o) | (|rf_wdata_o) | (|rf_be_o)}, 32'd0);
        psel_i = 0; penable_i = 0;
        step();
        rst_ni = 1;
        rf_ack_i = 1;
        step();
        rf_ack_i = 0;
        check("rst_ack_ign", {30'd0, pready_o, rf_req_o}, 0);
        step();
        check("rst_idle", {31'd0, pready_o}, 0);

        xfer(1, 16'h0024, 32'h0BADCAFE, 4'b0011, 0, 32'h0, 0);
        check("postrst_cyc", o_cyc, 3);
        check("postrst_reqs", o_reqs, 1);
        check("postrst_wdata", o_wdata, 32'h0BADCAFE);
        check("postrst_err", {31'd0, o_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/apb_slave_bridge.md
APB_SLAVE_BRIDGE -- requirements
Module: apb_slave_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BUS_WIDTH, 32, APB data width; multiple of 8.
- ADDR_WIDTH, 16, APB/RF address width.
- STRB_WIDTH, BUS_WIDTH/8, byte-lane count.
- TIMEOUT, 15, max WAIT cycles without rf_ack_i; 0 disables timeout.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, sole clock, rising edge.
- rst_ni, in, 1, asynchronous active-low reset.
- psel_i, in, 1, APB select.
- penable_i, in, 1, APB enable.
- pwrite_i, in, 1, 1=write, 0=read.
- paddr_i, in, ADDR_WIDTH, byte address.
- pwdata_i, in, BUS_WIDTH, write data.
- pstrb_i, in, STRB_WIDTH, write byte strobes.
- pready_o, out, 1, transfer complete.
- pslverr_o, out, 1, error response, valid only with pready_o.
- prdata_o, out, BUS_WIDTH, read data.
- busy_i, in, 1, core busy; writes are rejected while set.
- rf_req_o, out, 1, RF access request pulse.
- rf_we_o, out, 1, RF write enable.
- rf_addr_o, out, ADDR_WIDTH, RF address.
- rf_wdata_o, out, BUS_WIDTH, RF write data.
- rf_be_o, out, STRB_WIDTH, RF byte enables.
- rf_ack_i, in, 1, RF access done.
- rf_rdata_i, in, BUS_WIDTH, RF read data, valid with rf_ack_i.
- rf_err_i, in, 1, RF error (bad address), valid with rf_ack_i.

Function
REQ-003 All outputs SHALL be registered; FSM states: IDLE, REQ, WAIT, RESP.

REQ-004 IDLE, on psel_i=1 and penable_i=0:
- Capture paddr_i, pwrite_i, pwdata_i, pstrb_i.
- Go to REQ, unless REQ-005 or REQ-006 applies.

REQ-005 Rejected without RF access (IDLE -> RESP, pslverr_o=1):
- paddr_i low log2(STRB_WIDTH) bits nonzero (misaligned), or
- write with busy_i=1 at capture.

REQ-006 Write with pstrb_i=0 SHALL be a no-op: IDLE -> RESP, pslverr_o=0, no RF access.

REQ-007 REQ (exactly one cycle):
- rf_req_o=1; rf_we_o = captured pwrite; rf_addr_o = captured address.
- Write: rf_wdata_o = captured pwdata; rf_be_o = captured pstrb.
- Read: rf_be_o all ones.
- Next state WAIT.

REQ-008 WAIT, on rf_ack_i=1:
- Read: capture rf_rdata_i into prdata_o; write: prdata_o=0.
- pslverr_o=rf_err_i; go to RESP.

REQ-009 WAIT timeout: a counter SHALL count WAIT cycles. With TIMEOUT>0 and TIMEOUT cycles elapsed without ack, go to RESP with pslverr_o=1 and prdata_o=0.

REQ-010 RESP (one cycle):
- pready_o=1; next cycle pready_o=0, pslverr_o=0, prdata_o=0.
- Return to IDLE.

REQ-011 Zero-wait RF (ack in first WAIT cycle): pready_o SHALL assert in the 3rd cycle after the setup cycle, i.e. 2 APB wait states.

REQ-012 psel_i=0 while in REQ or WAIT (master abort):
- Finish the RF access (ack or timeout).
- Go to IDLE with pready_o held 0; the response is discarded.

REQ-013 rf_ack_i outside WAIT SHALL be ignored.

REQ-014 busy_i SHALL NOT affect reads or a transfer already past IDLE.

REQ-015 Only one transfer SHALL be outstanding; psel_i in REQ, WAIT or RESP does not start a new capture.

Reset
REQ-016 rst_ni=0 SHALL, asynchronously:
- Set state to IDLE and clear the timeout counter.
- Drive all outputs to 0: pready_o, pslverr_o, prdata_o, rf_req_o, rf_we_o, rf_addr_o, rf_wdata_o, rf_be_o.
- Abandon an in-flight transfer with no response.

REQ-017 After rst_ni rises, the first setup cycle SHALL be accepted normally.

Verification
REQ-018 Directed scenarios the bench SHALL cover:
- Write 0x0004 / 0xDEADBEEF / pstrb 0b0101, ack in first WAIT cycle -> one rf_req_o with be=0101, wdata=0xDEADBEEF; pready_o 3 cycles after setup; pslverr_o=0.
- Read 0x0008, rf_rdata_i=0x12345678 after 4 WAIT cycles -> prdata_o=0x12345678 with pready_o; rf_be_o=1111.
- Read with no ack, TIMEOUT=15 -> pready_o and pslverr_o=1 after 15 WAIT cycles; prdata_o=0.
- Write with busy_i=1, or read to 0x0003 -> no rf_req_o; pready_o with pslverr_o=1 on the cycle after setup.
- Write with pstrb_i=0 -> no rf_req_o; pready_o=1, pslverr_o=0.
- rst_ni low during WAIT -> all outputs 0 immediately; a later rf_ack_i is ignored; the next write completes normally.
